// File: rtl/pcm_to_pdm.sv
// PCM-to-PDM playback converter: sample FIFO, zero-order hold over OSR clocks,
// and a second-order sigma-delta modulator with saturating integrators.
module pcm_to_pdm #(
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int MAX_IN     = 26214
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pcm_in,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  input  logic        underrun_clr,
  output logic        pdm_out,
  output logic        sample_tick,
  output logic        underrun
);

  localparam int PW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = ACC_WIDTH + 2;

  localparam logic signed [ACC_WIDTH-1:0] MAX_X   = ACC_WIDTH'(MAX_IN);
  localparam logic signed [SW-1:0]        ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]        ACC_MIN = -ACC_MAX;
  localparam logic signed [SW-1:0]        FB_POS  = SW'(32768);
  localparam logic signed [SW-1:0]        FB_NEG  = -FB_POS;

  // ---------------------------------------------------------------- FIFO
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, boundary;

  logic [PW-1:0] phase;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign pcm_ready = !full;
  assign push      = pcm_valid && !full;
  assign boundary  = enable && (phase == PW'(OSR - 1));
  // A pop decision uses the pre-edge count, so a push into an empty FIFO on a
  // boundary edge is stored while the boundary takes the underrun path.
  assign pop       = boundary && !empty;

  // NOTE: sample storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pcm_in;
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------- modulator
  logic signed [15:0]          cur;
  logic signed [ACC_WIDTH-1:0] i1, i2;
  logic signed [ACC_WIDTH-1:0] x, i1_next, i2_next, cur_ext;
  logic signed [SW-1:0]        fb;
  logic                        idle;

  function automatic logic signed [SW-1:0] sext(input logic signed [ACC_WIDTH-1:0] v);
    return {{2{v[ACC_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > ACC_MAX)      return ACC_WIDTH'(ACC_MAX);
    else if (v < ACC_MIN) return ACC_WIDTH'(ACC_MIN);
    else                  return ACC_WIDTH'(v);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_ext = {{(ACC_WIDTH-16){cur[15]}}, cur};
    x       = cur_ext;
    if (cur_ext > MAX_X)       x = MAX_X;
    else if (cur_ext < -MAX_X) x = -MAX_X;
    fb      = pdm_out ? FB_POS : FB_NEG;
    i1_next = sat(sext(i1) + sext(x) - fb);
    i2_next = sat(sext(i2) + sext(i1_next) - fb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      i1          <= '0;
      i2          <= '0;
      pdm_out     <= 1'b0;
      idle        <= 1'b1;
      cur         <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (enable) begin
        phase   <= phase + PW'(1);
        i1      <= i1_next;
        i2      <= i2_next;
        pdm_out <= !i2_next[ACC_WIDTH-1];
        idle    <= 1'b0;
      end else begin
        // Idle pattern restarts at 1 on the first disabled cycle.
        phase   <= '0;
        i1      <= '0;
        i2      <= '0;
        pdm_out <= idle ? !pdm_out : 1'b1;
        idle    <= 1'b1;
      end

      sample_tick <= boundary;
      if (boundary) cur <= empty ? 16'sd0 : $signed(mem[rd_ptr]);

      if (boundary && empty) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Randomized self-checking bench for pcm_to_pdm against a cycle-level
// arithmetic reference model, plus density checks on DC streams.
module tb_pcm_to_pdm;

  localparam int    OSR     = 64;
  localparam int    DEPTH   = 4;
  localparam int    MAX_IN  = 26214;
  localparam longint ACC_MAX = (longint'(1) << 23) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        pcm_ready, pdm_out, sample_tick, underrun;

  pcm_to_pdm dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pcm_in(pcm_in),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .underrun_clr(underrun_clr),
    .pdm_out(pdm_out), .sample_tick(sample_tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: plain queue and integers.
  int     mq[$];
  int     m_phase, m_cur;
  longint m_i1, m_i2;
  bit     m_pdm, m_tick, m_und, m_idle;

  function automatic longint sat(input longint v);
    if (v > ACC_MAX)  return ACC_MAX;
    if (v < -ACC_MAX) return -ACC_MAX;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_cur = 0; m_i1 = 0; m_i2 = 0;
    m_pdm = 0; m_tick = 0; m_und = 0; m_idle = 1;
  endtask

  task automatic model_step();
    bit     push, bnd, set_u;
    longint x, fb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    push  = pcm_valid && (mq.size() < DEPTH);
    bnd   = enable && (m_phase == OSR - 1);
    set_u = 0;
    if (enable) begin
      x = m_cur;
      if (x > MAX_IN)  x = MAX_IN;
      if (x < -MAX_IN) x = -MAX_IN;
      fb = m_pdm ? 32768 : -32768;
      m_i1 = sat(m_i1 + x - fb);
      m_i2 = sat(m_i2 + m_i1 - fb);
      m_pdm = (m_i2 >= 0);
      m_idle = 0;
      m_phase = (m_phase + 1) % OSR;
    end else begin
      m_i1 = 0; m_i2 = 0; m_phase = 0;
      m_pdm = m_idle ? !m_pdm : 1'b1;
      m_idle = 1;
    end
    if (bnd) begin
      if (mq.size() > 0) m_cur = mq.pop_front();
      else begin
        m_cur = 0;
        set_u = 1;
      end
    end
    m_tick = bnd;
    if (set_u)             m_und = 1;
    else if (underrun_clr) m_und = 0;
    if (push) mq.push_back(int'($signed(pcm_in)));
  endtask

  task automatic compare_all();
    check("pdm_out", pdm_out, m_pdm);
    check("sample_tick", sample_tick, m_tick);
    check("underrun", underrun, m_und);
    check("pcm_ready", pcm_ready, (mq.size() < DEPTH));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Streams a constant level for n cycles; returns ones in the last w cycles.
  task automatic run_dc(input int lvl, input int n, input int w, output int ones);
    enable = 1; pcm_valid = 1; pcm_in = 16'(lvl);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i >= n - w) ones += int'(pdm_out);
    end
  endtask

  initial begin
    int acc, ticks, ones;
    bit seen_tick;
    logic [15:0] val;

    model_reset();
    #2;
    check("reset_pdm", pdm_out, 0);
    check("reset_ready", pcm_ready, 1);
    check("reset_underrun", underrun, 0);
    check("reset_tick", sample_tick, 0);
    cyc();
    rst_n = 1;

    // Idle pattern after reset: 1,0,1,0...
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("idle_toggle", pdm_out, (i % 2 == 0) ? 1 : 0);
    end

    // Fill while disabled with 1..5: only four are taken.
    acc = 0; val = 16'd1;
    pcm_valid = 1;
    for (int i = 0; i < 7; i++) begin
      pcm_in = val;
      if (pcm_ready) begin
        acc++;
        val++;
      end
      cyc();
    end
    check("hs_accepted", acc, 4);
    check("hs_ready_low", pcm_ready, 0);

    // Drain in order, then underrun at the fifth boundary.
    pcm_valid = 0; enable = 1;
    ticks = 0; seen_tick = 0;
    for (int i = 0; i < 5 * OSR + 2; i++) begin
      cyc();
      if (sample_tick) begin
        ticks++;
        if (!seen_tick) begin
          seen_tick = 1;
          check("ready_at_first_tick", pcm_ready, 1);
          check("first_tick_cycle", i, OSR - 1);
        end
      end
    end
    check("drain_ticks", ticks, 5);
    check("underrun_set", underrun, 1);

    ones = 0;
    for (int i = 0; i < OSR; i++) begin
      cyc();
      ones += int'(pdm_out);
    end
    check("underrun_density_ok", (ones >= 30 && ones <= 34), 1);

    underrun_clr = 1;
    cyc();
    underrun_clr = 0;
    check("underrun_cleared", underrun, 0);

    for (int i = 0; i < OSR && m_phase != OSR - 1; i++) cyc();
    check("at_boundary", m_phase, OSR - 1);
    underrun_clr = 1;
    cyc();
    underrun_clr = 0;
    check("set_wins_over_clr", underrun, 1);

    // DC densities.
    run_dc(0, 1024, 64, ones);
    check("dc_zero_frame_ok", (ones >= 30 && ones <= 34), 1);
    run_dc(16384, 2048, 512, ones);
    check("dc_pos_ok", (ones >= 380 && ones <= 388), 1);
    run_dc(-16384, 2048, 512, ones);
    check("dc_neg_ok", (ones >= 124 && ones <= 132), 1);
    run_dc(32767, 2048, 1024, ones);
    check("clamp_max_ok", (ones >= 916 && ones <= 928), 1);
    run_dc(26214, 2048, 1024, ones);
    check("clamp_ref_ok", (ones >= 916 && ones <= 928), 1);
    run_dc(-32768, 2048, 1024, ones);
    check("clamp_min_ok", (ones >= 96 && ones <= 108), 1);

    // Randomized traffic with occasional enable toggles and clears.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) enable = !enable;
      pcm_valid    = ($urandom_range(0, 99) < 4);
      pcm_in       = 16'($urandom);
      underrun_clr = ($urandom_range(0, 99) < 5);
      cyc();
    end

    // Mid-frame asynchronous reset.
    enable = 1; pcm_valid = 1; underrun_clr = 0; pcm_in = 16'sd20000;
    for (int i = 0; i < 100; i++) cyc();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("midreset_pdm", pdm_out, 0);
    check("midreset_ready", pcm_ready, 1);
    check("midreset_tick", sample_tick, 0);
    check("midreset_underrun", underrun, 0);
    pcm_valid = 0; enable = 0;
    cyc();
    #2;
    rst_n = 1;
    enable = 1;
    for (int i = 0; i < OSR + 4; i++) cyc();
    check("post_reset_underrun", underrun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
